// File: rtl/rgb_pwm_driver_pkg.sv
// Shared types and constants for the RGB PWM driver and its colour source.
package rgb_pkg;

  localparam int PWM_BITS_DEFAULT = 8;
  localparam int CLK_HZ           = 12_000_000;

  typedef struct packed {
    logic [PWM_BITS_DEFAULT-1:0] r;
    logic [PWM_BITS_DEFAULT-1:0] g;
    logic [PWM_BITS_DEFAULT-1:0] b;
  } rgb_t;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Valid/ready colour-word channel from the sequencer into the PWM driver.
interface rgb_pwm_driver_if #(
  parameter int PWM_BITS = 8
);

  logic                in_valid;
  logic                in_ready;
  logic [PWM_BITS-1:0] in_r;
  logic [PWM_BITS-1:0] in_g;
  logic [PWM_BITS-1:0] in_b;

  modport master (output in_valid, output in_r, output in_g, output in_b, input in_ready);
  modport slave  (input in_valid, input in_r, input in_g, input in_b, output in_ready);

endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM pin: duty comparator against the shared phase, registered, with optional inversion.
module pwm_channel #(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] phase,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pin
);

  logic r_pin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pin <= ACTIVE_LOW;
    end else begin
      r_pin <= (phase < duty) ^ ACTIVE_LOW;
    end
  end

  assign pin = r_pin;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver: prescaled phase counter, one-deep pending colour word
// that is only promoted to the active duty at a period boundary.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEFAULT,
  parameter int PRESCALE   = 47,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  rgb_pwm_driver_if.slave   s_if,
  output logic              RGB_R,
  output logic              RGB_G,
  output logic              RGB_B,
  output logic              frame_start
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     r_prescale;
  logic [PWM_BITS-1:0] r_phase;
  logic                r_pending_full;
  logic                r_in_ready;
  logic                r_boundary_d;
  logic                r_frame_start;
  logic                w_step_tick;
  logic                w_boundary;
  logic                w_accept;
  logic [PWM_BITS-1:0] w_in   [3];
  logic [PWM_BITS-1:0] r_pend [3];
  logic [PWM_BITS-1:0] r_duty [3];
  logic                w_pin  [3];

  assign w_step_tick = (r_prescale == PS_LAST);
  assign w_boundary  = w_step_tick && (r_phase == '1);
  assign w_accept    = s_if.in_valid && r_in_ready;

  assign w_in[0] = s_if.in_r;
  assign w_in[1] = s_if.in_g;
  assign w_in[2] = s_if.in_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_phase    <= '0;
    end else begin
      r_prescale <= w_step_tick ? '0 : r_prescale + 1'b1;
      if (w_step_tick) begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  // accept and promotion are mutually exclusive because in_ready mirrors !pending_full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending_full <= 1'b0;
      r_in_ready     <= 1'b0;
    end else if (w_accept) begin
      r_pending_full <= 1'b1;
      r_in_ready     <= 1'b0;
    end else if (w_boundary && r_pending_full) begin
      r_pending_full <= 1'b0;
      r_in_ready     <= 1'b1;
    end else begin
      r_in_ready     <= !r_pending_full;
    end
  end

  // frame_start lines up with the first pin sample of phase 0, two edges after the boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_boundary_d  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_boundary_d  <= w_boundary;
      r_frame_start <= r_boundary_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pend[gi] <= '0;
          r_duty[gi] <= '0;
        end else begin
          if (w_accept) begin
            r_pend[gi] <= w_in[gi];
          end
          if (w_boundary && r_pending_full) begin
            r_duty[gi] <= r_pend[gi];
          end
        end
      end

      pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .phase (r_phase),
        .duty  (r_duty[gi]),
        .pin   (w_pin[gi])
      );
    end
  endgenerate

  assign s_if.in_ready = r_in_ready;
  assign frame_start   = r_frame_start;
  assign RGB_R         = w_pin[0];
  assign RGB_G         = w_pin[1];
  assign RGB_B         = w_pin[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench: two drivers (active-high and active-low pins) with PRESCALE=2, so a period is 512 clocks.
module tb_rgb_pwm_driver;
  import rgb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pins0;
  logic [2:0] pins1;
  logic       fs0;
  logic       fs1;
  int         n_checks = 0;
  int         n_pass   = 0;

  rgb_pwm_driver_if #(.PWM_BITS(8)) bus0 ();
  rgb_pwm_driver_if #(.PWM_BITS(8)) bus1 ();

  rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(2), .ACTIVE_LOW(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (bus0.slave),
    .RGB_R       (pins0[0]),
    .RGB_G       (pins0[1]),
    .RGB_B       (pins0[2]),
    .frame_start (fs0)
  );

  rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk         (clk),
    .rst         (rst),
    .s_if        (bus1.slave),
    .RGB_R       (pins1[0]),
    .RGB_G       (pins1[1]),
    .RGB_B       (pins1[2]),
    .frame_start (fs1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [2:0] pins(input int s);
    return (s != 0) ? pins1 : pins0;
  endfunction

  function automatic logic fs(input int s);
    return (s != 0) ? fs1 : fs0;
  endfunction

  function automatic logic rdy(input int s);
    return (s != 0) ? bus1.in_ready : bus0.in_ready;
  endfunction

  task automatic drive(input int s, input logic v, input rgb_t c);
    if (s != 0) begin
      bus1.in_valid = v; bus1.in_r = c.r; bus1.in_g = c.g; bus1.in_b = c.b;
    end else begin
      bus0.in_valid = v; bus0.in_r = c.r; bus0.in_g = c.g; bus0.in_b = c.b;
    end
  endtask

  task automatic send(input int s, input rgb_t c, input string tag);
    int waited = 0;
    drive(s, 1'b1, c);
    while (!rdy(s) && waited < 1100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready"}, int'(rdy(s)), 1);
    @(negedge clk);
    drive(s, 1'b0, c);
    $display("send %s dut%0d rgb=(%0d,%0d,%0d) waited=%0d", tag, s, c.r, c.g, c.b, waited);
  endtask

  task automatic wait_frame(input int s, input string tag, output int cycles);
    cycles = 0;
    while (!fs(s) && cycles < 1100) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_frame_seen"}, int'(fs(s)), 1);
  endtask

  // Entered on a frame_start cycle; counts high cycles per pin over one full period.
  task automatic measure(input int s, input string tag, input int er, input int eg, input int eb);
    int h0 = 0;
    int h1 = 0;
    int h2 = 0;
    logic [2:0] p;
    for (int i = 0; i < 512; i++) begin
      p = pins(s);
      h0 += int'(p[0]);
      h1 += int'(p[1]);
      h2 += int'(p[2]);
      @(negedge clk);
    end
    check({tag, "_r_high"}, h0, er);
    check({tag, "_g_high"}, h1, eg);
    check({tag, "_b_high"}, h2, eb);
    check({tag, "_next_frame"}, int'(fs(s)), 1);
    $display("period %s dut%0d high=(%0d,%0d,%0d)", tag, s, h0, h1, h2);
  endtask

  initial begin
    int cyc;
    drive(0, 1'b0, '{8'd0, 8'd0, 8'd0});
    drive(1, 1'b0, '{8'd0, 8'd0, 8'd0});

    // reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dut0_state", {pins(0), rdy(0), fs(0)}, 0);
      check("rst_dut1_pins", pins(1), 7);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", rdy(0), 1);
    wait_frame(0, "rel", cyc);
    check("rel_first_frame", cyc, 512);

    // basic duty
    send(0, '{8'd128, 8'd0, 8'd255}, "basic");
    wait_frame(0, "basic", cyc);
    check("basic_first_pins", pins(0), 3'b101);
    measure(0, "basic", 256, 0, 510);

    // backpressure: A accepted, B held until A promoted
    send(0, '{8'd10, 8'd20, 8'd30}, "bp_a");
    drive(0, 1'b1, '{8'd40, 8'd50, 8'd60});
    cyc = 0;
    while (!rdy(0) && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_ready_before_frame", {rdy(0), fs(0)}, 2'b10);
    @(negedge clk);
    drive(0, 1'b0, '{8'd0, 8'd0, 8'd0});
    $display("send bp_b dut0 rgb=(40,50,60) waited=%0d", cyc);
    check("bp_b_taken", {rdy(0), fs(0)}, 2'b01);
    measure(0, "bp_a", 20, 40, 60);
    measure(0, "bp_b", 80, 100, 120);

    // word presented on the boundary edge itself
    repeat (510) @(negedge clk);
    check("coll_ready", rdy(0), 1);
    drive(0, 1'b1, '{8'd200, 8'd0, 8'd0});
    @(negedge clk);
    drive(0, 1'b0, '{8'd0, 8'd0, 8'd0});
    $display("send coll dut0 rgb=(200,0,0) on boundary");
    check("coll_fs_lag", fs(0), 0);
    @(negedge clk);
    check("coll_fs", fs(0), 1);
    measure(0, "coll_old", 80, 100, 120);
    measure(0, "coll_new", 400, 0, 0);

    // reset mid-period with a pending word
    send(0, '{8'd128, 8'd128, 8'd128}, "mid_act");
    wait_frame(0, "mid_act", cyc);
    send(0, '{8'd1, 8'd1, 8'd1}, "mid_pend");
    repeat (200) @(negedge clk);
    check("mid_pins_on", pins(0), 7);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_state", {pins(0), rdy(0), fs(0)}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_ready", {rdy(0), pins(0)}, 4'b1000);
    wait_frame(0, "mid_rel", cyc);
    check("mid_rel_frame", cyc, 512);
    measure(0, "mid_after", 0, 0, 0);

    // inverted pins
    wait_frame(1, "al_zero", cyc);
    measure(1, "al_zero", 512, 512, 512);
    send(1, '{8'd255, 8'd255, 8'd255}, "al_full");
    wait_frame(1, "al_full", cyc);
    measure(1, "al_full", 2, 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage for the RGB colour sequencer. It takes 8-bit-per-channel colour words over a valid/ready handshake and drives the RGB_R/RGB_G/RGB_B pins with PWM, so colours can be dimmed and faded instead of only switched on and off.
- New colour words are applied only at PWM period boundaries, which keeps the outputs glitch-free.
- Targets the 12 MHz board clock.

Parameters:
- PWM_BITS, 8: duty and phase width; one period is 2**PWM_BITS steps.
- PRESCALE, 47: clocks per PWM step (12 MHz / 47 / 256 ≈ 997 Hz period rate). Must be ≥ 1.
- ACTIVE_LOW, 0: when 1, every pin output is inverted.

Ports:
- clk  in  1  system clock, 12 MHz
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  colour word valid
- in_ready  out  1  driver can accept a word
- in_r  in  PWM_BITS  red duty
- in_g  in  PWM_BITS  green duty
- in_b  in  PWM_BITS  blue duty
- RGB_R  out  1  red PWM pin
- RGB_G  out  1  green PWM pin
- RGB_B  out  1  blue PWM pin
- frame_start  out  1  one-cycle pulse at the start of each PWM period

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. All outputs are registered.
- Reset values:
  - prescaler = 0, phase = 0, active duty = 0 on all channels.
  - pending register empty.
  - in_ready = 0 while rst is high.
  - frame_start = 0.
  - Pins show the "off" level (0, or 1 if ACTIVE_LOW).
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - step_tick = (prescaler == PRESCALE-1).
  - PRESCALE = 1 gives step_tick every clock.
- Phase:
  - PWM_BITS-wide counter; increments on step_tick.
  - Wraps 2**PWM_BITS-1 -> 0.
  - boundary = step_tick && phase == all-ones.
- Handshake:
  - Word accepted on a clock edge with in_valid && in_ready; it is captured into the pending register and pending_full <= 1.
  - in_ready = !pending_full, registered.
  - After reset deasserts, in_ready = 1 from the first cycle.
  - in_r/g/b are don't-care unless in_valid is high. The upstream may hold in_valid high indefinitely.
- Apply:
  - On a boundary edge with pending_full = 1: active duty <= pending, pending_full <= 0.
  - With pending_full = 0: active duty is unchanged.
- Simultaneous accept and boundary: the accepted word goes into pending and is applied at the next boundary, never the current one. Pending is not bypassed.
- Channel output: pin <= (phase < duty) XOR ACTIVE_LOW, registered, so the pin lags phase by 1 clock.
  - duty 0: never on.
  - duty 2**PWM_BITS-1: on for 2**PWM_BITS-1 of 2**PWM_BITS steps.
  - Full-on is not reachable, by design.
- frame_start: registered high for one clock, in the same cycle the pins first reflect phase 0 (the edge after the boundary edge).
- Reset mid-operation:
  - Drops the pending word and clears active duty.
  - Pins go to "off" on the edge where rst is sampled high.
  - No partial period completes.

Decomposition:
- Package rgb_pkg:
  - typedef rgb_t: packed struct {r, g, b}, each logic [PWM_BITS-1:0].
  - Localparam PWM_BITS_DEFAULT = 8.
  - Localparam CLK_HZ = 12_000_000.
- Sub-module pwm_channel: comparator plus output register with polarity. Ports: clk, rst, phase, duty, pin. Instantiated three times.
- The top level holds the prescaler, phase counter, pending/active registers and handshake.

Test Plan:
All scenarios use PRESCALE=2, PWM_BITS=8, so one period is 512 clocks.
1. Reset: rst high for 3 cycles -> pins 0, in_ready 0, frame_start 0 throughout. The cycle after release, in_ready = 1. The first frame_start occurs 512 clocks later.
2. Basic duty: send (128, 0, 255) once -> after the next frame_start, each 512-clock period shows RGB_R high for 256 clocks, RGB_G high for 0, RGB_B high for 510. The high span starts on the frame_start cycle.
3. Backpressure: send A = (10, 20, 30), then hold in_valid with B = (40, 50, 60) -> in_ready stays 0 until the cycle after A's boundary, then B is accepted. A is active for one period and B from the following period. No word is lost or duplicated.
4. Boundary collision: with pending empty, present (200, 0, 0) exactly on the boundary edge -> the current period uses the old duty, and 200 applies from the period after next frame_start (+512 clocks).
5. Polarity: ACTIVE_LOW = 1 with duty (0, 0, 0) -> all pins constant 1. With (255, 255, 255) -> each pin low for 510 clocks per period.
6. Reset mid-period: active (128, 128, 128), pending full with (1, 1, 1), rst pulsed at phase 100 -> pins off on the next edge and stay off. Afterwards no duty is applied without a new word, in_ready = 1, and frame_start resumes 512 clocks after release.
